// File: rtl/modulo_debouncer_botoes_pkg.sv
// Shared debouncer types: FSM state encoding and default timing constants.
// The AUTO_REPEAT_EN macro selects the optional auto-repeat feature in the channel.
package pkg_debouncer;

    // Bit 1 of the encoding is the debounced level itself.
    typedef enum logic [1:0] {
        SOLTO       = 2'b00,
        CONF_PRESS  = 2'b01,
        PRESSIONADO = 2'b11,
        CONF_SOLTA  = 2'b10
    } estado_t;

    localparam int N_BOTOES_PAD     = 2;
    localparam int CONT_ESTAVEL_PAD = 1000000;
    localparam int W_CONT_PAD       = 20;
    localparam int ATRASO_PAD       = 25000000;
    localparam int PERIODO_PAD      = 5000000;

endpackage

// File: rtl/modulo_debouncer_canal.sv
// One button channel: 2-FF synchroniser, confirmation FSM, press pulse.
// With AUTO_REPEAT_EN defined, a hold counter adds repeat pulses while pressed.
module modulo_debouncer_canal
    import pkg_debouncer::*;
#(
    parameter int CONT_ESTAVEL      = CONT_ESTAVEL_PAD,
    parameter int W_CONT            = W_CONT_PAD,
    parameter int ATRASO_REPETICAO  = ATRASO_PAD,
    parameter int PERIODO_REPETICAO = PERIODO_PAD
) (
    input  logic clk,
    input  logic clr,
    input  logic btn_n,
    output logic nivel,
    output logic pulso
);

    localparam logic [W_CONT-1:0] ALVO = W_CONT'(CONT_ESTAVEL);

    logic              sync1, sync2, s;
    estado_t           estado, prox;
    logic [W_CONT-1:0] cnt, cnt_prox;
    logic              pulso_q, pulso_prox;
    logic              aceita, rep;

    always_ff @(posedge clk) begin
        if (clr) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
        end
    end

    assign s = ~sync2;

    always_ff @(posedge clk) begin
        if (clr) begin
            estado  <= SOLTO;
            cnt     <= '0;
            pulso_q <= 1'b0;
        end else begin
            estado  <= prox;
            cnt     <= cnt_prox;
            pulso_q <= pulso_prox;
        end
    end

    always_comb begin
        prox     = estado;
        cnt_prox = cnt;
        unique case (estado)
            SOLTO: begin
                if (s) begin
                    prox     = CONF_PRESS;
                    cnt_prox = W_CONT'(1);
                end
            end
            CONF_PRESS: begin
                if (!s) begin
                    prox     = SOLTO;
                    cnt_prox = '0;
                end else if (cnt == ALVO) begin
                    prox     = PRESSIONADO;
                    cnt_prox = '0;
                end else begin
                    cnt_prox = cnt + W_CONT'(1);
                end
            end
            PRESSIONADO: begin
                if (!s) begin
                    prox     = CONF_SOLTA;
                    cnt_prox = W_CONT'(1);
                end
            end
            CONF_SOLTA: begin
                if (s) begin
                    prox     = PRESSIONADO;
                    cnt_prox = '0;
                end else if (cnt == ALVO) begin
                    prox     = SOLTO;
                    cnt_prox = '0;
                end else begin
                    cnt_prox = cnt + W_CONT'(1);
                end
            end
            default: begin
                prox     = SOLTO;
                cnt_prox = '0;
            end
        endcase
    end

`ifdef AUTO_REPEAT_EN
    localparam int W_H = (ATRASO_REPETICAO > 1) ? $clog2(ATRASO_REPETICAO) : 1;
    localparam logic [W_H-1:0] H_ALVO = W_H'(ATRASO_REPETICAO - 1);
    localparam logic [W_H-1:0] H_REC  = W_H'(ATRASO_REPETICAO - PERIODO_REPETICAO);

    logic [W_H-1:0] hcnt, hcnt_prox;

    always_ff @(posedge clk) begin
        if (clr) hcnt <= '0;
        else     hcnt <= hcnt_prox;
    end

    // Reload to ATRASO-PERIODO so later repeats come every PERIODO cycles.
    always_comb begin
        hcnt_prox = hcnt;
        rep       = 1'b0;
        if (estado == PRESSIONADO) begin
            if (s) begin
                if (hcnt == H_ALVO) begin
                    rep       = 1'b1;
                    hcnt_prox = H_REC;
                end else begin
                    hcnt_prox = hcnt + W_H'(1);
                end
            end
        end else if (estado == CONF_SOLTA) begin
            if (!s && cnt == ALVO) hcnt_prox = '0;
        end else begin
            hcnt_prox = '0;
        end
    end
`else
    assign rep = 1'b0;
`endif

    always_comb begin
        aceita     = (estado == CONF_PRESS) && s && (cnt == ALVO);
        pulso_prox = aceita | rep;
        nivel      = estado[1];
        pulso      = pulso_q;
    end

endmodule

// File: rtl/modulo_debouncer_botoes.sv
// Debounced operator buttons: N_BOTOES independent channels.
// Define AUTO_REPEAT_EN to enable auto-repeat pulses while a button is held.
module modulo_debouncer_botoes
    import pkg_debouncer::*;
#(
    parameter int N_BOTOES          = N_BOTOES_PAD,
    parameter int CONT_ESTAVEL      = CONT_ESTAVEL_PAD,
    parameter int W_CONT            = W_CONT_PAD,
    parameter int ATRASO_REPETICAO  = ATRASO_PAD,
    parameter int PERIODO_REPETICAO = PERIODO_PAD
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [N_BOTOES-1:0] btn_n,
    output logic [N_BOTOES-1:0] nivel,
    output logic [N_BOTOES-1:0] pulso
);

    for (genvar i = 0; i < N_BOTOES; i++) begin : g_canal
        modulo_debouncer_canal #(
            .CONT_ESTAVEL      (CONT_ESTAVEL),
            .W_CONT            (W_CONT),
            .ATRASO_REPETICAO  (ATRASO_REPETICAO),
            .PERIODO_REPETICAO (PERIODO_REPETICAO)
        ) u_canal (
            .clk   (clk),
            .clr   (clr),
            .btn_n (btn_n[i]),
            .nivel (nivel[i]),
            .pulso (pulso[i])
        );
    end

endmodule

// File: tb/tb_modulo_debouncer_botoes.sv
// Directed bench for modulo_debouncer_botoes (CONT_ESTAVEL=4, W_CONT=3).
// Repeat expectations follow AUTO_REPEAT_EN (ATRASO=10, PERIODO=5).
module tb_modulo_debouncer_botoes;

    logic       clk = 1'b0;
    logic       clr;
    logic [1:0] btn_n;
    logic [1:0] nivel;
    logic [1:0] pulso;

    int n_chk  = 0;
    int n_fail = 0;

    modulo_debouncer_botoes #(
        .N_BOTOES          (2),
        .CONT_ESTAVEL      (4),
        .W_CONT            (3),
        .ATRASO_REPETICAO  (10),
        .PERIODO_REPETICAO (5)
    ) dut (
        .clk   (clk),
        .clr   (clr),
        .btn_n (btn_n),
        .nivel (nivel),
        .pulso (pulso)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [1:0]  acc_n, acc_p;
    logic [31:0] mask, exp_mask;

    initial begin
        clr   = 1'b1;
        btn_n = 2'b11;
        tick(3);
        check("reset_nivel", 32'(nivel), 32'h0);
        check("reset_pulso", 32'(pulso), 32'h0);
        clr = 1'b0;
        tick(2);

        // 1: clean press on channel 0
        btn_n = 2'b10;
        tick(6);
        check("t1_pre_nivel", 32'(nivel), 32'h0);
        tick(1);
        check("t1_nivel", 32'(nivel), 32'h1);
        check("t1_pulso", 32'(pulso), 32'h1);
        tick(1);
        check("t1_pulso_off", 32'(pulso), 32'h0);
        check("t1_hold_nivel", 32'(nivel), 32'h1);
        btn_n = 2'b11;
        tick(6);
        check("t1_rel_pre", 32'(nivel), 32'h1);
        tick(1);
        check("t1_rel_nivel", 32'(nivel), 32'h0);
        check("t1_rel_pulso", 32'(pulso), 32'h0);
        tick(3);

        // 2: 2-cycle glitch rejected
        acc_n = '0;
        acc_p = '0;
        btn_n = 2'b10;
        tick(2);
        btn_n = 2'b11;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            acc_n |= nivel;
            acc_p |= pulso;
        end
        check("t2_nivel", 32'(acc_n), 32'h0);
        check("t2_pulso", 32'(acc_p), 32'h0);

        // 3: bouncing release
        btn_n = 2'b10;
        tick(7);
        check("t3_press", 32'(pulso), 32'h1);
        tick(2);
        acc_p = '0;
        acc_n = 2'b11;
        for (int i = 0; i < 6; i++) begin
            btn_n = (i % 2 == 0) ? 2'b11 : 2'b10;
            tick(1);
            acc_p |= pulso;
            acc_n &= nivel;
        end
        btn_n = 2'b11;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            acc_p |= pulso;
            acc_n &= nivel;
        end
        check("t3_bounce_nivel", 32'(acc_n[0]), 32'h1);
        check("t3_bounce_pulso", 32'(acc_p), 32'h0);
        tick(1);
        check("t3_fall", 32'(nivel), 32'h0);
        tick(3);

        // 4: simultaneous presses
        btn_n = 2'b00;
        tick(6);
        check("t4_pre", 32'(pulso), 32'h0);
        tick(1);
        check("t4_pulso", 32'(pulso), 32'h3);
        check("t4_nivel", 32'(nivel), 32'h3);
        tick(1);
        check("t4_pulso_off", 32'(pulso), 32'h0);
        btn_n = 2'b11;
        tick(7);
        check("t4_rel", 32'(nivel), 32'h0);
        tick(3);

        // 5: clr aborts a confirmation in progress
        btn_n = 2'b10;
        tick(4);
        clr = 1'b1;
        tick(1);
        check("t5_clr_nivel", 32'(nivel), 32'h0);
        clr   = 1'b0;
        acc_p = '0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            acc_p |= pulso;
        end
        check("t5_no_early", 32'(acc_p), 32'h0);
        tick(1);
        check("t5_pulso", 32'(pulso), 32'h1);

        // 6: repeat pattern while held, k=0 is the accept cycle
        mask = 32'h1;
        for (int k = 1; k < 30; k++) begin
            tick(1);
            if (pulso[0]) mask[k] = 1'b1;
        end
`ifdef AUTO_REPEAT_EN
        exp_mask = (32'h1 << 0) | (32'h1 << 10) | (32'h1 << 15) |
                   (32'h1 << 20) | (32'h1 << 25);
`else
        exp_mask = 32'h1;
`endif
        check("t6_repeat", mask, exp_mask);
        check("t6_nivel", 32'(nivel), 32'h1);
        btn_n = 2'b11;
        tick(7);
        check("t6_rel", 32'(nivel), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
